segway_math_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational Segway math block. It takes PID controller effort and steering-pot samples and produces saturated signed left/right motor speeds plus a persistence-filtered `too_fast` flag. The soft-start timer is generated internally, and samples are qualified by a valid strobe. It sits between the PID block and the motor-drive/PWM block.

---
 rtl/segway_math_pkg.sv | 29 ++
 rtl/segway_math_pipe_ss_ramp.sv | 21 ++
 rtl/segway_math_pipe.sv | 153 +++++++++++++++
 tb/tb_segway_math_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/segway_math_pkg.sv
// Shared defaults and saturation helper for the Segway math pipeline.
package segway_math_pkg;

  localparam int unsigned DEF_W               = 12;
  localparam int unsigned DEF_SS_BITS         = 8;
  localparam int unsigned DEF_STEER_MIN       = 'h200;
  localparam int unsigned DEF_STEER_MAX       = 'hE00;
  localparam int unsigned DEF_MIN_DUTY        = 'h3C0;
  localparam int unsigned DEF_LOW_TORQUE_BAND = 'h03C;
  localparam int unsigned DEF_GAIN_MULT       = 16;
  localparam int          DEF_TOO_FAST_LIM    = 1536;
  localparam int unsigned DEF_FAST_PERSIST    = 4;

  // Clamp x into the signed range of a w-bit word; caller truncates to w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)
      return hi;
    else if (x < lo)
      return lo;
    else
      return x;
  endfunction

endpackage

// File: rtl/segway_math_pipe_ss_ramp.sv
// Soft-start ramp: saturating counter advanced by ss_tick while the rider is present.
module ss_ramp #(
  parameter int unsigned SS_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwr_up,
  input  logic               ss_tick,
  output logic [SS_BITS-1:0] ss_tmr
);

  always_ff @(posedge clk) begin
    if (rst)
      ss_tmr <= '0;
    else if (!pwr_up)
      ss_tmr <= '0;
    else if (ss_tick && (ss_tmr != '1))
      ss_tmr <= ss_tmr + 1'b1;
  end

endmodule

// File: rtl/segway_math_pipe.sv
// Pipelined Segway math: soft-start scaling, steering mix, torque shaping with
// saturation, and a persistence-filtered over-speed flag.
module segway_math_pipe
  import segway_math_pkg::*;
#(
  parameter int unsigned W               = DEF_W,
  parameter int unsigned SS_BITS         = DEF_SS_BITS,
  parameter int unsigned STEER_MIN       = DEF_STEER_MIN,
  parameter int unsigned STEER_MAX       = DEF_STEER_MAX,
  parameter int unsigned MIN_DUTY        = DEF_MIN_DUTY,
  parameter int unsigned LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
  parameter int unsigned GAIN_MULT       = DEF_GAIN_MULT,
  parameter int          TOO_FAST_LIM    = DEF_TOO_FAST_LIM,
  parameter int unsigned FAST_PERSIST    = DEF_FAST_PERSIST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwr_up,
  input  logic                ss_tick,
  input  logic                in_vld,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic        [W-1:0] steer_pot,
  input  logic                en_steer,
  output logic                out_vld,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                too_fast,
  output logic [SS_BITS-1:0]  ss_tmr
);

  localparam int unsigned XW = W + 24;
  localparam int unsigned SW = W + 3;
  localparam int unsigned CW = $clog2(FAST_PERSIST + 1);

  localparam logic        [W-1:0]  S_MIN = W'(STEER_MIN);
  localparam logic        [W-1:0]  S_MAX = W'(STEER_MAX);
  localparam logic signed [SW-1:0] MID   = SW'((1 << (W - 1)) - 1);
  localparam logic signed [XW-1:0] LTB   = XW'(LOW_TORQUE_BAND);
  localparam logic signed [XW-1:0] GM    = XW'(GAIN_MULT);
  localparam logic signed [XW-1:0] MD    = XW'(MIN_DUTY);
  localparam logic signed [W-1:0]  TFL   = W'(TOO_FAST_LIM);
  localparam logic        [CW-1:0] FP    = CW'(FAST_PERSIST);

  ss_ramp #(.SS_BITS(SS_BITS)) u_ss_ramp (
    .clk     (clk),
    .rst     (rst),
    .pwr_up  (pwr_up),
    .ss_tick (ss_tick),
    .ss_tmr  (ss_tmr)
  );

  // Capture stage: ss_tmr is latched alongside the sample, before any increment.
  logic                vld0, vld1, vld2;
  logic signed [W-1:0] pid_q;
  logic        [W-1:0] pot_q;
  logic                en_q;
  logic [SS_BITS-1:0]  ss_q;

  logic signed [W-1:0] pid_ss, steer;
  logic signed [W:0]   lft_t, rght_t;
  logic [CW-1:0]       fast_cnt;

  logic signed [W+SS_BITS:0] prod;
  logic        [W-1:0]       pot_clip;
  logic signed [SW-1:0]      steer_off, steer_x3;
  logic signed [W-1:0]       pid_ss_n, steer_n;

  always_comb begin
    prod = pid_q * $signed({1'b0, ss_q});
    pid_ss_n = W'(prod >>> SS_BITS);
    if (pot_q < S_MIN)
      pot_clip = S_MIN;
    else if (pot_q > S_MAX)
      pot_clip = S_MAX;
    else
      pot_clip = pot_q;
    steer_off = $signed({3'b000, pot_clip}) - MID;
    steer_x3  = steer_off + (steer_off <<< 1);
    steer_n   = en_q ? W'(steer_x3 >>> 4) : '0;
  end

  function automatic logic signed [W-1:0] shape(input logic signed [W:0] t);
    logic signed [XW-1:0] tx;
    logic signed [XW-1:0] mag;
    logic signed [XW-1:0] r;
    tx  = XW'(t);
    mag = (tx < 0) ? -tx : tx;
    if (mag > LTB)
      r = tx * GM;
    else if (tx >= 0)
      r = tx + MD;
    else
      r = tx - MD;
    return W'(sat_signed(64'(r), W));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      vld2     <= 1'b0;
      out_vld  <= 1'b0;
      pid_q    <= '0;
      pot_q    <= '0;
      en_q     <= 1'b0;
      ss_q     <= '0;
      pid_ss   <= '0;
      steer    <= '0;
      lft_t    <= '0;
      rght_t   <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      vld0    <= in_vld;
      vld1    <= vld0;
      vld2    <= vld1;
      out_vld <= vld2;
      if (in_vld) begin
        pid_q <= PID_cntrl;
        pot_q <= steer_pot;
        en_q  <= en_steer;
        ss_q  <= ss_tmr;
      end
      if (vld0) begin
        pid_ss <= pid_ss_n;
        steer  <= steer_n;
      end
      if (vld1) begin
        lft_t  <= {pid_ss[W-1], pid_ss} + {steer[W-1], steer};
        rght_t <= {pid_ss[W-1], pid_ss} - {steer[W-1], steer};
      end
      if (vld2) begin
        lft_spd  <= pwr_up ? shape(lft_t)  : '0;
        rght_spd <= pwr_up ? shape(rght_t) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !pwr_up)
      fast_cnt <= '0;
    else if (out_vld) begin
      if ((lft_spd > TFL) || (rght_spd > TFL)) begin
        if (fast_cnt != FP)
          fast_cnt <= fast_cnt + 1'b1;
      end else
        fast_cnt <= '0;
    end
  end

  assign too_fast = (fast_cnt == FP);

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed, table-driven bench for segway_math_pipe with hand-computed expectations.
module tb_segway_math_pipe;

  logic               clk = 1'b0;
  logic               rst, pwr_up, ss_tick, in_vld, en_steer;
  logic        [11:0] PID_cntrl, steer_pot;
  logic               out_vld, too_fast;
  logic signed [11:0] lft_spd, rght_spd;
  logic        [7:0]  ss_tmr;

  int errors = 0;
  int checks = 0;

  localparam logic [11:0] OVER = 12'h5FF;
  localparam logic [11:0] INLIM = 12'h010;

  segway_math_pipe #(.W(12), .SS_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwr_up    (pwr_up),
    .ss_tick   (ss_tick),
    .in_vld    (in_vld),
    .PID_cntrl (PID_cntrl),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .out_vld   (out_vld),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .too_fast  (too_fast),
    .ss_tmr    (ss_tmr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pid;
    logic [11:0] pot;
    logic        en;
    int          l;
    int          r;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [11:0] pid, input int n);
    PID_cntrl = pid;
    steer_pot = 12'h800;
    en_steer  = 1'b0;
    in_vld    = 1'b1;
    for (int k = 0; k < n; k++) tick();
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ramp_full();
    pwr_up  = 1'b1;
    ss_tick = 1'b1;
    idle(256);
    ss_tick = 1'b0;
    chk("ramp_full", int'(ss_tmr), 255);
  endtask

  initial begin
    vec[0]  = '{12'h5FF, 12'h800, 1'b0,  2047,  2047};
    vec[1]  = '{12'h010, 12'h800, 1'b0,   975,   975};
    vec[2]  = '{12'hFF0, 12'h800, 1'b0,  -976,  -976};
    vec[3]  = '{12'h000, 12'hFFF, 1'b1,  2047, -2048};
    vec[4]  = '{12'h000, 12'hFFF, 1'b0,   960,   960};
    vec[5]  = '{12'h000, 12'h000, 1'b1, -2048,  2047};
    vec[6]  = '{12'h000, 12'h807, 1'b1,   961,  -961};
    vec[7]  = '{12'h03D, 12'h800, 1'b0,  1020,  1020};
    vec[8]  = '{12'h03E, 12'h800, 1'b0,   976,   976};
    vec[9]  = '{12'hFC3, 12'h800, 1'b0,  -976,  -976};
    vec[10] = '{12'hFC4, 12'h800, 1'b0, -1020, -1020};
    vec[11] = '{12'h064, 12'h800, 1'b0,  1584,  1584};

    rst = 1'b1; pwr_up = 1'b0; ss_tick = 1'b0; in_vld = 1'b0; en_steer = 1'b0;
    PID_cntrl = '0; steer_pot = 12'h800;
    idle(2);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_lft", int'(lft_spd), 0);
    chk("rst_rght", int'(rght_spd), 0);
    chk("rst_ss_tmr", int'(ss_tmr), 0);
    chk("rst_too_fast", int'(too_fast), 0);
    rst = 1'b0;

    // Ramp counts up, saturates, then clear beats a simultaneous tick.
    pwr_up = 1'b1; ss_tick = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      chk("ramp", int'(ss_tmr), (i > 255) ? 255 : i);
    end
    pwr_up = 1'b0;
    tick();
    chk("ramp_clear", int'(ss_tmr), 0);
    ramp_full();

    // Back-to-back vectors, results three edges after capture.
    for (int j = 0; j < NV + 3; j++) begin
      if (j < NV) begin
        PID_cntrl = vec[j].pid;
        steer_pot = vec[j].pot;
        en_steer  = vec[j].en;
        in_vld    = 1'b1;
      end else
        in_vld = 1'b0;
      tick();
      if (j >= 3) begin
        chk("vec_vld", int'(out_vld), 1);
        chk($sformatf("vec%0d_lft", j - 3), int'(lft_spd), vec[j-3].l);
        chk($sformatf("vec%0d_rght", j - 3), int'(rght_spd), vec[j-3].r);
      end else
        chk("vec_vld_lead", int'(out_vld), 0);
    end
    idle(2);
    chk("hold_vld", int'(out_vld), 0);
    chk("hold_lft", int'(lft_spd), vec[NV-1].l);
    chk("hold_rght", int'(rght_spd), vec[NV-1].r);

    // Persistence filter.
    send(INLIM, 1); idle(5);
    chk("tf_clear", int'(too_fast), 0);
    send(OVER, 3); send(INLIM, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("tf_3_then_in", int'(too_fast), 0);
    end
    send(OVER, 4); idle(3);
    chk("tf_before_4th", int'(too_fast), 0);
    idle(1);
    chk("tf_after_4th", int'(too_fast), 1);
    send(INLIM, 1); idle(5);
    chk("tf_reclear", int'(too_fast), 0);
    send(OVER, 2); idle(6);
    chk("tf_gap_mid", int'(too_fast), 0);
    send(OVER, 2); idle(3);
    chk("tf_gap_pre", int'(too_fast), 0);
    idle(1);
    chk("tf_gap_set", int'(too_fast), 1);

    // pwr_up low at S3 capture zeroes speeds but keeps the valid.
    send(OVER, 1); idle(2);
    pwr_up = 1'b0;
    tick();
    chk("pwr_s3_vld", int'(out_vld), 1);
    chk("pwr_s3_lft", int'(lft_spd), 0);
    chk("pwr_s3_rght", int'(rght_spd), 0);
    tick();
    chk("pwr_tf_clear", int'(too_fast), 0);
    chk("pwr_ss_clear", int'(ss_tmr), 0);

    // Reset with three samples in flight.
    ramp_full();
    send(OVER, 4); idle(5);
    chk("pre_rst_tf", int'(too_fast), 1);
    PID_cntrl = OVER; in_vld = 1'b1;
    idle(3);
    in_vld = 1'b0; rst = 1'b1;
    tick();
    chk("mid_rst_vld", int'(out_vld), 0);
    chk("mid_rst_lft", int'(lft_spd), 0);
    chk("mid_rst_rght", int'(rght_spd), 0);
    chk("mid_rst_tf", int'(too_fast), 0);
    chk("mid_rst_ss", int'(ss_tmr), 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_rst_no_vld", int'(out_vld), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
